// File: rtl/divu_pkg.sv
// Shared types for the multicycle unsigned divider.
package divu_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } divu_state_t;

endpackage

// File: rtl/adder_n.sv
// Plain N-bit ripple-style adder with carry-in; the carry-out is dropped.
module adder_n #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum
);

  assign sum = a + b + {{(N-1){1'b0}}, c_in};

endmodule

// File: rtl/div_step.sv
// One combinational restoring-division step: trial subtract at N+1 bits, keep or restore.
module div_step #(
  parameter int N = 32
) (
  input  logic [N:0]   partial,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] next_rem,
  output logic         q_bit
);

  logic [N:0] diff;

  // Two's-complement subtract; diff[N] set means partial < divisor (borrow).
  adder_n #(.N(N + 1)) u_sub (
    .a    (partial),
    .b    (~{1'b0, divisor}),
    .c_in (1'b1),
    .sum  (diff)
  );

  assign q_bit    = ~diff[N];
  assign next_rem = q_bit ? diff[N-1:0] : partial[N-1:0];

endmodule

// File: rtl/divu_multicycle.sv
// Multicycle unsigned divider (DIVU/REMU): one restoring step per clock, fixed N-cycle latency.
module divu_multicycle
  import divu_pkg::*;
#(
  parameter int N  = 32,
  parameter int CW = $clog2(N + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         ready,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  divu_state_t   state_q, state_d;
  logic [CW-1:0] counter_q, counter_d;
  logic [N-1:0]  q_shreg_q, q_shreg_d;
  logic [N-1:0]  rem_q, rem_d;
  logic [N-1:0]  div_q, div_d;
  logic [N-1:0]  quot_q, quot_d;
  logic [N-1:0]  remr_q, remr_d;
  logic          dbz_q, dbz_d;

  logic [N-1:0]  step_rem;
  logic          step_q;

  div_step #(.N(N)) u_step (
    .partial  ({rem_q, q_shreg_q[N-1]}),
    .divisor  (div_q),
    .next_rem (step_rem),
    .q_bit    (step_q)
  );

  // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    q_shreg_d = q_shreg_q;
    rem_d     = rem_q;
    div_d     = div_q;
    quot_d    = quot_q;
    remr_d    = remr_q;
    dbz_d     = dbz_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          q_shreg_d = dividend;
          rem_d     = '0;
          div_d     = divisor;
          dbz_d     = (divisor == '0);
          counter_d = '0;
          state_d   = S_BUSY;
        end
      end
      S_BUSY: begin
        rem_d     = step_rem;
        q_shreg_d = {q_shreg_q[N-2:0], step_q};
        counter_d = counter_q + CW'(1);
        // Final step: publish the post-step values directly so they appear with done.
        if (counter_q == CW'(N - 1)) begin
          quot_d  = {q_shreg_q[N-2:0], step_q};
          remr_d  = step_rem;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      counter_q <= '0;
      q_shreg_q <= '0;
      rem_q     <= '0;
      div_q     <= '0;
      quot_q    <= '0;
      remr_q    <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      q_shreg_q <= q_shreg_d;
      rem_q     <= rem_d;
      div_q     <= div_d;
      quot_q    <= quot_d;
      remr_q    <= remr_d;
      dbz_q     <= dbz_d;
    end
  end

  assign ready       = (state_q == S_IDLE);
  assign done        = (state_q == S_DONE);
  assign quotient    = quot_q;
  assign remainder   = remr_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divu_multicycle.sv
// Self-checking bench for divu_multicycle: N=32 directed/random scenarios and an N=8 random sweep.
module tb_divu_multicycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] dividend, divisor;
  logic        ready, done, div_by_zero;
  logic [31:0] quotient, remainder;

  logic        start8;
  logic [7:0]  dividend8, divisor8;
  logic        ready8, done8, dbz8;
  logic [7:0]  quotient8, remainder8;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  divu_multicycle #(.N(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready       (ready),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  divu_multicycle #(.N(8)) dut8 (
    .clk         (clk),
    .rst         (rst),
    .start       (start8),
    .dividend    (dividend8),
    .divisor     (divisor8),
    .ready       (ready8),
    .done        (done8),
    .quotient    (quotient8),
    .remainder   (remainder8),
    .div_by_zero (dbz8)
  );

  // Reference: RISC-V DIVU/REMU semantics
  function automatic logic [31:0] ref_q32(input logic [31:0] a, input logic [31:0] b);
    return (b == 0) ? 32'hFFFF_FFFF : a / b;
  endfunction
  function automatic logic [31:0] ref_r32(input logic [31:0] a, input logic [31:0] b);
    return (b == 0) ? a : a % b;
  endfunction

  // Issue one op on the 32-bit DUT from a negedge; returns edges from acceptance to done.
  task automatic do_op32(input logic [31:0] a, input logic [31:0] b, output int lat);
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL op32_ready_before: ready=%b expected 1", ready);
    end
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (ready !== 1'b0) begin
      failures++;
      $display("FAIL op32_ready_drop: ready=%b expected 0", ready);
    end
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_result32(input string name, input logic [31:0] a, input logic [31:0] b,
                                input int lat);
    checks++;
    if (lat != 32) begin
      failures++;
      $display("FAIL %s_latency: got %0d expected 32", name, lat);
    end
    checks++;
    if (quotient !== ref_q32(a, b) || remainder !== ref_r32(a, b) ||
        div_by_zero !== (b == 0)) begin
      failures++;
      $display("FAIL %s_result: a=%h b=%h got q=%h r=%h dbz=%b expected q=%h r=%h dbz=%b",
               name, a, b, quotient, remainder, div_by_zero, ref_q32(a, b), ref_r32(a, b), b == 0);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_after_done: done=%b ready=%b expected done=0 ready=1", name, done, ready);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0; dividend = '0; divisor = '0;
    start8 = 1'b0; dividend8 = '0; divisor8 = '0;
    #1;
    checks++;
    if (ready !== 1'b1 || done !== 1'b0 || quotient !== 32'd0 || remainder !== 32'd0 ||
        div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: ready=%b done=%b q=%h r=%h dbz=%b expected 1 0 0 0 0",
               ready, done, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat;
    do_op32(32'd100, 32'd7, lat);
    check_result32("basic_100_7", 32'd100, 32'd7, lat);
  endtask

  task automatic test_corners;
    logic [31:0] as [5] = '{32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'd12345, 32'd0};
    logic [31:0] bs [5] = '{32'd100, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0};
    int lat;
    for (int i = 0; i < 5; i++) begin
      do_op32(as[i], bs[i], lat);
      check_result32($sformatf("corner%0d", i), as[i], bs[i], lat);
    end
  endtask

  task automatic test_random32;
    logic [31:0] a, b;
    int lat;
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 3 == 1) b = b >> $urandom_range(31, 8);
      do_op32(a, b, lat);
      check_result32($sformatf("rand%0d", i), a, b, lat);
    end
  endtask

  task automatic test_ignore_start;
    int dones = 0;
    int c;
    logic held_ok = 1'b1;
    dividend = 32'd1000;
    divisor  = 32'd10;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (c = 1; c <= 45; c++) begin
      start = (c == 5 || c == 20);
      if (c == 5 || c == 20) begin
        dividend = 32'd9;
        divisor  = 32'd3;
      end else if (c < 32) begin
        dividend = $urandom;
        divisor  = $urandom;
      end
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    start = 1'b0;
    checks++;
    if (dones != 1) begin
      failures++;
      $display("FAIL ignore_start_dones: got %0d expected 1", dones);
    end
    checks++;
    if (quotient !== 32'd100 || remainder !== 32'd0 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL ignore_start_result: q=%0d r=%0d dbz=%b expected 100 0 0",
               quotient, remainder, div_by_zero);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (quotient !== 32'd100 || remainder !== 32'd0 || done !== 1'b0 || ready !== 1'b1)
        held_ok = 1'b0;
    end
    checks++;
    if (held_ok !== 1'b1) begin
      failures++;
      $display("FAIL idle_hold: q=%0d r=%0d done=%b ready=%b expected 100 0 0 1",
               quotient, remainder, done, ready);
    end
  endtask

  task automatic test_reset_abort;
    int dones = 0;
    int lat;
    dividend = 32'd50;
    divisor  = 32'd5;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b1 || done !== 1'b0 || quotient !== 32'd0 || remainder !== 32'd0 ||
        div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_abort_state: ready=%b done=%b q=%h r=%h dbz=%b expected 1 0 0 0 0",
               ready, done, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      failures++;
      $display("FAIL reset_abort_no_done: got %0d done pulses expected 0", dones);
    end
    do_op32(32'd50, 32'd5, lat);
    check_result32("after_abort_50_5", 32'd50, 32'd5, lat);
  endtask

  task automatic test_n8;
    logic [7:0] a, b, eq, er;
    int lat;
    int bad = 0;
    int ops = 0;
    for (int i = 0; i < 1500; i++) begin
      if (i < 16) begin
        a = (i[1:0] == 0) ? 8'd0 : (i[1:0] == 1) ? 8'd1 : (i[1:0] == 2) ? 8'hFE : 8'hFF;
        b = (i[3:2] == 0) ? 8'd0 : (i[3:2] == 1) ? 8'd1 : (i[3:2] == 2) ? 8'h80 : 8'hFF;
      end else begin
        a = 8'($urandom);
        b = 8'($urandom);
      end
      eq = (b == 0) ? 8'hFF : a / b;
      er = (b == 0) ? a : a % b;
      dividend8 = a;
      divisor8  = b;
      start8    = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      lat = 0;
      while (done8 !== 1'b1 && lat < 30) begin
        @(negedge clk);
        lat++;
      end
      ops++;
      if (lat != 8 || quotient8 !== eq || remainder8 !== er || dbz8 !== (b == 0)) begin
        bad++;
        if (bad <= 5)
          $display("FAIL n8_op: a=%h b=%h lat=%0d q=%h r=%h dbz=%b expected lat=8 q=%h r=%h dbz=%b",
                   a, b, lat, quotient8, remainder8, dbz8, eq, er, b == 0);
      end
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL n8_sweep: %0d of %0d ops wrong, expected 0", bad, ops);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_random32();
    test_ignore_start();
    test_reset_abort();
    test_n8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
